// File: rtl/sr_fetch_queue.sv
// rtl/sr_fetch_queue.sv - instruction prefetch queue with redirect flush and stale-response drop
module sr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    input  logic        instrReady,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          DEPTH_M1  = DEPTH - 1;
    localparam logic [AW:0] L_DEPTH   = DEPTH[AW:0];
    localparam logic [AW:0] L_DEPTHM1 = DEPTH_M1[AW:0];

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DROP} state_t;

    state_t        r_state, w_state_next;
    // r_fetch_pc is the PC of the outstanding (or next) request, so it stays put
    // while a request is in flight; a redirect during a wait is parked in r_pend_pc.
    logic [31:0]   r_fetch_pc, w_fetch_pc_next;
    logic [31:0]   r_pend_pc, w_pend_pc_next;
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [AW:0]   r_count, w_count_next, w_count_after_pop;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic          w_push, w_pop;
    logic [31:0]   w_redirect_pc;

    assign w_redirect_pc     = redirectPc & 32'hFFFF_FFFC;
    assign instrValid        = (r_count != '0);
    assign instr             = r_fifo_instr[r_rd_ptr];
    assign instrPc           = r_fifo_pc[r_rd_ptr];
    assign memReq            = (r_state != ST_IDLE);
    assign memAddr           = {2'b00, r_fetch_pc[31:2]};
    assign w_pop             = instrValid && instrReady && !redirect;
    assign w_count_after_pop = r_count - {{AW{1'b0}}, w_pop};
    assign w_count_next      = redirect ? '0 : (w_count_after_pop + {{AW{1'b0}}, w_push});

    // FSM state and fetch PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_pend_pc  <= w_pend_pc_next;
        end
    end

    // Next-state logic: issue only while queued entries plus the new request fit
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_pend_pc_next  = r_pend_pc;
        w_push          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_next = w_redirect_pc;
                    w_state_next    = ST_REQ;
                end else if (w_count_after_pop < L_DEPTH) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    if (memAck) begin
                        w_fetch_pc_next = w_redirect_pc;
                        w_state_next    = ST_REQ;
                    end else begin
                        w_pend_pc_next = w_redirect_pc;
                        w_state_next   = ST_DROP;
                    end
                end else if (memAck) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                    w_state_next    = (w_count_after_pop < L_DEPTHM1) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (memAck) begin
                    w_fetch_pc_next = redirect ? w_redirect_pc : r_pend_pc;
                    w_state_next    = ST_REQ;
                end else if (redirect) begin
                    w_pend_pc_next = w_redirect_pc;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FIFO pointers, occupancy and storage; a redirect empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_count <= w_count_next;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= memData;
                    r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
                    r_wr_ptr               <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end
endmodule
